// File: rtl/rr_multi_sel_pkg.sv
// Shared constants and helpers for the round-robin multi-grant selector.
package rr_sel_pkg;

    localparam int DEF_REQS = 8;
    localparam int DEF_GNTS = 2;

    // Increment an index modulo reqs, which need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned reqs);
        return (idx + 1 >= reqs) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_multi_sel_if.sv
// Request/grant bundle between a requester group and rr_multi_sel.
interface rr_multi_sel_if #(
    parameter int REQS = rr_sel_pkg::DEF_REQS,
    parameter int GNTS = rr_sel_pkg::DEF_GNTS
);
    localparam int IDX_W = $clog2(REQS);

    logic [REQS-1:0]       req;
    logic                  en;
    logic [REQS-1:0]       gnt;
    logic [GNTS*REQS-1:0]  gnt_bus;
    logic [GNTS*IDX_W-1:0] gnt_idx;
    logic [GNTS-1:0]       gnt_valid;
    logic                  empty;

    // Selector side.
    modport slave (
        input  req, en,
        output gnt, gnt_bus, gnt_idx, gnt_valid, empty
    );

    // Requester side.
    modport master (
        output req, en,
        input  gnt, gnt_bus, gnt_idx, gnt_valid, empty
    );

endinterface

// File: rtl/rr_multi_sel_find_first.sv
// Finds the first set request bit at or after ptr, wrapping modulo REQS.
module rr_find_first
    import rr_sel_pkg::*;
#(
    parameter int REQS  = DEF_REQS,
    parameter int IDX_W = $clog2(REQS)
) (
    input  logic [REQS-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [REQS-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Walk the rotated order once; the first hit wins.
    always_comb begin
        int pos;
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        pos      = int'(ptr_i);
        for (int i = 0; i < REQS; i++) begin
            if (!valid_o && req_i[pos]) begin
                onehot_o[pos] = 1'b1;
                idx_o         = IDX_W'(pos);
                valid_o       = 1'b1;
            end
            pos = int'(wrap_inc(pos, REQS));
        end
    end

endmodule

// File: rtl/rr_multi_sel.sv
// Round-robin N-of-M grant selector with rotating priority pointer.
// Optional output register stage: define RR_MULTI_SEL_REG_OUT_EN.
module rr_multi_sel
    import rr_sel_pkg::*;
#(
    parameter int REQS = DEF_REQS,
    parameter int GNTS = DEF_GNTS
) (
    input  logic          clock,
    input  logic          reset_n,
    rr_multi_sel_if.slave bus
);

    localparam int IDX_W = $clog2(REQS);

    logic [IDX_W-1:0]            ptr_q, ptr_d;
    logic [GNTS:0][REQS-1:0]     avail;
    logic [GNTS-1:0][REQS-1:0]   oh;
    logic [GNTS-1:0][IDX_W-1:0]  idx;
    logic [GNTS-1:0]             vld;
    logic [REQS-1:0]             gnt_c;
    logic [IDX_W-1:0]            last_idx;

    assign avail[0] = bus.req;

    // Each slot searches from the same pointer but only sees requests not taken by earlier slots.
    for (genvar k = 0; k < GNTS; k++) begin : g_slot
        rr_find_first #(.REQS(REQS), .IDX_W(IDX_W)) u_ff (
            .req_i    (avail[k]),
            .ptr_i    (ptr_q),
            .onehot_o (oh[k]),
            .idx_o    (idx[k]),
            .valid_o  (vld[k])
        );
        assign avail[k+1] = avail[k] & ~oh[k];
    end

    // Merge slot grants and locate the last filled slot (valid slots are contiguous from 0).
    always_comb begin
        gnt_c    = '0;
        last_idx = '0;
        for (int k = 0; k < GNTS; k++) begin
            gnt_c = gnt_c | oh[k];
            if (vld[k]) last_idx = idx[k];
        end
    end

    // Next pointer: one past the lowest-priority winner, only when grants are consumed.
    always_comb begin
        ptr_d = ptr_q;
        if (bus.en && |bus.req) ptr_d = IDX_W'(wrap_inc(int'(last_idx), REQS));
    end

    // Pointer register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

`ifdef RR_MULTI_SEL_REG_OUT_EN
    logic [REQS-1:0]       gnt_q;
    logic [GNTS*REQS-1:0]  gnt_bus_q;
    logic [GNTS*IDX_W-1:0] gnt_idx_q;
    logic [GNTS-1:0]       gnt_valid_q;
    logic                  empty_q;

    // Output register stage; clears asynchronously with the pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q       <= '0;
            gnt_bus_q   <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= '0;
            empty_q     <= 1'b1;
        end else begin
            gnt_q       <= gnt_c;
            gnt_bus_q   <= oh;
            gnt_idx_q   <= idx;
            gnt_valid_q <= vld;
            empty_q     <= ~|bus.req;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_bus   = gnt_bus_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.empty     = empty_q;
`else
    assign bus.gnt       = gnt_c;
    assign bus.gnt_bus   = oh;
    assign bus.gnt_idx   = idx;
    assign bus.gnt_valid = vld;
    assign bus.empty     = ~|bus.req;
`endif

endmodule

// File: tb/tb_rr_multi_sel.sv
// Scoreboard bench for rr_multi_sel (REQS=8, GNTS=2, combinational outputs).
module tb_rr_multi_sel;

    localparam int REQS = 8;
    localparam int GNTS = 2;

    typedef struct {
        string      name;
        logic [7:0] gnt;
        logic [7:0] b1, b0;
        logic [2:0] i1, i0;
        logic [1:0] vld;
        logic       empty;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ptr_m = 0;
    exp_t expq[$];

    rr_multi_sel_if #(.REQS(REQS), .GNTS(GNTS)) bus ();

    rr_multi_sel #(.REQS(REQS), .GNTS(GNTS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [7:0] g, input logic [7:0] b1, input logic [7:0] b0,
                                input logic [2:0] i1, input logic [2:0] i0, input logic [1:0] v);
        exp_t x;
        x.name = ""; x.gnt = g; x.b1 = b1; x.b0 = b0; x.i1 = i1; x.i0 = i0; x.vld = v;
        x.empty = (v == 2'b00);
        return x;
    endfunction

    // Behavioural reference: scan the rotated order, fill slots in turn.
    function automatic void model(input logic [7:0] r, input int p, output exp_t x, output int np);
        int k, last, j;
        x = mk(8'h0, 8'h0, 8'h0, 3'd0, 3'd0, 2'b00);
        x.empty = (r == 8'h0);
        k = 0; last = -1;
        for (int i = 0; i < REQS; i++) begin
            j = (p + i) % REQS;
            if (r[j] && k < GNTS) begin
                x.gnt[j] = 1'b1;
                if (k == 0) begin x.b0[j] = 1'b1; x.i0 = 3'(j); x.vld[0] = 1'b1; end
                else        begin x.b1[j] = 1'b1; x.i1 = 3'(j); x.vld[1] = 1'b1; end
                k++; last = j;
            end
        end
        np = (last < 0) ? p : (last + 1) % REQS;
    endfunction

    task automatic drive(input string nm, input logic [7:0] r, input logic e, input exp_t x);
        exp_t mx; int np;
        @(posedge clock); #1;
        bus.req = r; bus.en = e;
        model(r, ptr_m, mx, np);
        if (e) ptr_m = np;
        x.name = nm;
        expq.push_back(x);
    endtask

    task automatic drive_rand(input int n);
        exp_t mx; int np; logic [7:0] r; logic e;
        @(posedge clock); #1;
        r = 8'($urandom);
        if ((n % 7) == 0) r = 8'h0;
        e = ($urandom_range(0, 3) != 0);
        bus.req = r; bus.en = e;
        model(r, ptr_m, mx, np);
        if (e) ptr_m = np;
        mx.name = "rand";
        expq.push_back(mx);
    endtask

    // Assert reset in the middle of a cycle; expectation is checked before any clock edge.
    task automatic reset_mid(input string nm, input logic [7:0] r, input logic e, input exp_t x);
        @(posedge clock); #1;
        reset_n = 1'b0;
        bus.req = r; bus.en = e;
        ptr_m = 0;
        x.name = nm;
        expq.push_back(x);
    endtask

    task automatic release_rst();
        @(posedge clock); #1;
        bus.req = 8'h0; bus.en = 1'b0;
        reset_n = 1'b1;
        ptr_m = 0;
    endtask

    // Monitor: outputs are combinational, so every negedge with a pending entry is a response.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                x = expq.pop_front();
                checks++;
                if (bus.gnt !== x.gnt || bus.gnt_bus !== {x.b1, x.b0} ||
                    bus.gnt_idx !== {x.i1, x.i0} || bus.gnt_valid !== x.vld ||
                    bus.empty !== x.empty) begin
                    errors++;
                    $display("FAIL %s: got gnt=%h bus=%h idx=%h vld=%b empty=%b want gnt=%h bus=%h idx=%h vld=%b empty=%b",
                             x.name, bus.gnt, bus.gnt_bus, bus.gnt_idx, bus.gnt_valid, bus.empty,
                             x.gnt, {x.b1, x.b0}, {x.i1, x.i0}, x.vld, x.empty);
                end
                checks++;
                if ((bus.gnt_bus[15:8] & bus.gnt_bus[7:0]) != 8'h0) begin
                    errors++;
                    $display("FAIL disjoint(%s): slot1=%h slot0=%h required no overlap",
                             x.name, bus.gnt_bus[15:8], bus.gnt_bus[7:0]);
                end
            end
        end
    end

    initial begin
        bus.req = 8'h0; bus.en = 1'b0;
        repeat (2) @(posedge clock);
        release_rst();

        drive("rst_ff_a",  8'hFF, 1'b1, mk(8'h03, 8'h02, 8'h01, 3'd1, 3'd0, 2'b11));
        drive("ff_ptr2",   8'hFF, 1'b1, mk(8'h0C, 8'h08, 8'h04, 3'd3, 3'd2, 2'b11));
        drive("ff_ptr4",   8'hFF, 1'b1, mk(8'h30, 8'h20, 8'h10, 3'd5, 3'd4, 2'b11));
        drive("single6",   8'h40, 1'b1, mk(8'h40, 8'h00, 8'h40, 3'd0, 3'd6, 2'b01));
        drive("wrap7_0",   8'h81, 1'b1, mk(8'h81, 8'h01, 8'h80, 3'd0, 3'd7, 2'b11));
        drive("single2",   8'h04, 1'b1, mk(8'h04, 8'h00, 8'h04, 3'd0, 3'd2, 2'b01));
        drive("empty_a",   8'h00, 1'b1, mk(8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 2'b00));
        drive("empty_b",   8'h00, 1'b0, mk(8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 2'b00));
        drive("ptr3_hold", 8'hFF, 1'b0, mk(8'h18, 8'h10, 8'h08, 3'd4, 3'd3, 2'b11));

        reset_mid("rst_ptr3", 8'hFF, 1'b0, mk(8'h03, 8'h02, 8'h01, 3'd1, 3'd0, 2'b11));
        release_rst();
        drive("en0_a",     8'hFF, 1'b0, mk(8'h03, 8'h02, 8'h01, 3'd1, 3'd0, 2'b11));
        drive("en0_b",     8'hFF, 1'b0, mk(8'h03, 8'h02, 8'h01, 3'd1, 3'd0, 2'b11));
        drive("en0_c",     8'hFF, 1'b0, mk(8'h03, 8'h02, 8'h01, 3'd1, 3'd0, 2'b11));
        drive("en1",       8'hFF, 1'b1, mk(8'h03, 8'h02, 8'h01, 3'd1, 3'd0, 2'b11));
        drive("adv_ptr2",  8'hFF, 1'b0, mk(8'h0C, 8'h08, 8'h04, 3'd3, 3'd2, 2'b11));
        drive("single3",   8'h08, 1'b1, mk(8'h08, 8'h00, 8'h08, 3'd0, 3'd3, 2'b01));
        drive("single4",   8'h10, 1'b1, mk(8'h10, 8'h00, 8'h10, 3'd0, 3'd4, 2'b01));
        drive("ptr5",      8'hFF, 1'b0, mk(8'h60, 8'h40, 8'h20, 3'd6, 3'd5, 2'b11));
        reset_mid("rst_ptr5", 8'hFF, 1'b0, mk(8'h03, 8'h02, 8'h01, 3'd1, 3'd0, 2'b11));
        release_rst();
        drive("last7",     8'h80, 1'b1, mk(8'h80, 8'h00, 8'h80, 3'd0, 3'd7, 2'b01));
        drive("wrap_to0",  8'h03, 1'b1, mk(8'h03, 8'h02, 8'h01, 3'd1, 3'd0, 2'b11));

        for (int n = 0; n < 10000; n++) drive_rand(n);

        @(posedge clock);
        @(negedge clock); #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
